// File: rtl/skew_buffer_pkg.sv
// Shared definitions for the skew buffer: FSM encoding and drain length.
package skew_buffer_pkg;

    localparam int DRAIN_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Cycles needed to flush the deepest channel once the last column is in.
    function automatic logic [DRAIN_CNT_W-1:0] drain_len(input int base_delay, input int num_ch);
        return DRAIN_CNT_W'(base_delay + num_ch - 1);
    endfunction

endpackage

// File: rtl/skew_buffer_if.sv
// Column-in / skewed-column-out bundle of the skew buffer.
interface skew_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4
);
    logic                         in_valid;
    logic                         in_last;
    logic [NUM_CH*DATA_WIDTH-1:0] data_in;
    logic                         in_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] data_out;
    logic [NUM_CH-1:0]            out_valid;
    logic                         busy;
    logic                         done;

    modport master (
        output in_valid, in_last, data_in,
        input  in_ready, data_out, out_valid, busy, done
    );

    modport slave (
        input  in_valid, in_last, data_in,
        output in_ready, data_out, out_valid, busy, done
    );
endinterface

// File: rtl/skew_buffer_line.sv
// One channel of the skew buffer: a shift line of DEPTH stages carrying data and valid.
module skew_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]                 valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (shift_en) begin
            data_d[0]  = load_data;
            valid_d[0] = load_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/skew_buffer.sv
// Skews a tile of columns so channel c lags by BASE_DELAY + c advances, then drains it.
//   state    | meaning
//   ST_IDLE  | no tile in flight, lines hold zero
//   ST_RUN   | accepting columns, lines advance on each accepted beat
//   ST_DRAIN | last column taken, lines advance every cycle with zero fill
module skew_buffer
    import skew_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int BASE_DELAY = 1
) (
    input logic          clk,
    input logic          rst_n,
    skew_buffer_if.slave bus
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LEN = drain_len(BASE_DELAY, NUM_CH);

    state_e                 state_q, state_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
    logic                   done_q, done_d;

    logic accept;
    logic shift_en;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] line_data;
    logic [NUM_CH-1:0]                 line_valid;

    assign accept   = bus.in_valid && (state_q != ST_DRAIN);
    assign shift_en = accept || (state_q == ST_DRAIN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    if (bus.in_last) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LEN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - DRAIN_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_line
        skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BASE_DELAY + c)
        ) u_line (
            .clk        (clk),
            .rst_n      (rst_n),
            .shift_en   (shift_en),
            .load_data  (accept ? bus.data_in[c*DATA_WIDTH +: DATA_WIDTH] : '0),
            .load_valid (accept),
            .out_data   (line_data[c]),
            .out_valid  (line_valid[c])
        );
    end

    assign bus.data_out  = line_data;
    assign bus.out_valid = line_valid;
    assign bus.in_ready  = (state_q != ST_DRAIN);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_skew_buffer.sv
// Bench for skew_buffer: directed tiles plus random traffic against a column-history model.
module tb_skew_buffer;

    localparam int W4 = 8;
    localparam int N4 = 4;
    localparam int B4 = 1;
    localparam int W8 = 8;
    localparam int N8 = 8;
    localparam int B8 = 2;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    skew_buffer_if #(.DATA_WIDTH(W4), .NUM_CH(N4)) bus4 ();
    skew_buffer_if #(.DATA_WIDTH(W8), .NUM_CH(N8)) bus8 ();

    skew_buffer #(.DATA_WIDTH(W4), .NUM_CH(N4), .BASE_DELAY(B4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    skew_buffer #(.DATA_WIDTH(W8), .NUM_CH(N8), .BASE_DELAY(B8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: every advance appends one column; channel c shows the
    // column appended D(c) advances ago.
    logic [N4*W4-1:0] hist_d[$];
    bit               hist_v[$];
    int               m_state;    // 0 idle, 1 run, 2 drain
    int               m_left;
    bit               m_done;

    logic [3:0] ramp [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1100, 4'b1000, 4'b0000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        hist_d.delete();
        hist_v.delete();
        m_state = 0;
        m_left  = 0;
        m_done  = 0;
    endtask

    task automatic model_edge(input bit v, input bit l, input logic [N4*W4-1:0] d);
        bit ready;
        bit acc;
        ready  = (m_state != 2);
        acc    = v && ready;
        m_done = (m_state == 2) && (m_left == 1);
        if (acc) begin
            hist_d.push_back(d);
            hist_v.push_back(1'b1);
        end else if (m_state == 2) begin
            hist_d.push_back('0);
            hist_v.push_back(1'b0);
        end
        if (m_state == 2) begin
            m_left--;
            if (m_left == 0) m_state = 0;
        end else if (acc) begin
            if (l) begin
                m_state = 2;
                m_left  = B4 + N4 - 1;
            end else begin
                m_state = 1;
            end
        end
    endtask

    task automatic compare_all(input string pfx);
        logic [N4*W4-1:0] ed;
        logic [N4-1:0]    ev;
        ed = '0;
        ev = '0;
        for (int c = 0; c < N4; c++) begin
            int idx;
            idx = hist_d.size() - (B4 + c);
            if (idx >= 0) begin
                ed[c*W4 +: W4] = hist_d[idx][c*W4 +: W4];
                ev[c]          = hist_v[idx];
            end
        end
        chk({pfx, "_data_out"},  64'(bus4.data_out),  64'(ed));
        chk({pfx, "_out_valid"}, 64'(bus4.out_valid), 64'(ev));
        chk({pfx, "_in_ready"},  64'(bus4.in_ready),  64'(m_state != 2));
        chk({pfx, "_busy"},      64'(bus4.busy),      64'(m_state != 0));
        chk({pfx, "_done"},      64'(bus4.done),      64'(m_done));
    endtask

    task automatic cycle(input string pfx, input bit v, input bit l, input logic [N4*W4-1:0] d);
        bus4.in_valid = v;
        bus4.in_last  = l;
        bus4.data_in  = d;
        @(posedge clk);
        model_edge(v, l, d);
        #1;
        compare_all(pfx);
    endtask

    task automatic do_reset(input string pfx);
        rst_n = 1'b0;
        model_clear();
        #1;
        compare_all({pfx, "_async"});
        chk({pfx, "_dut8_valid"}, 64'(bus8.out_valid), 64'h0);
        chk({pfx, "_dut8_ready"}, 64'(bus8.in_ready),  64'h1);
        @(posedge clk);
        #1;
        compare_all({pfx, "_hold"});
        rst_n = 1'b1;
    endtask

    function automatic logic [N4*W4-1:0] col(input int k);
        logic [N4*W4-1:0] r;
        for (int c = 0; c < N4; c++) r[c*W4 +: W4] = W4'(16 * k + c);
        return r;
    endfunction

    task automatic tile_basic(input string pfx);
        for (int k = 0; k < 8; k++) begin
            if (k < 4) cycle(pfx, 1'b1, k == 3, col(k));
            else       cycle(pfx, 1'b0, 1'b0, '0);
            chk({pfx, "_ramp"},      64'(bus4.out_valid), 64'(ramp[k]));
            chk({pfx, "_done_time"}, 64'(bus4.done),      64'(k == 7));
            if (k == 2) chk({pfx, "_ch2_first"}, 64'(bus4.data_out[23:16]), 64'h02);
        end
        cycle(pfx, 1'b0, 1'b0, '0);
        chk({pfx, "_done_once"}, 64'(bus4.done), 64'h0);
    endtask

    initial begin
        logic [N4*W4-1:0] all_aa;
        int lat0, lat7, busy_cnt, done_at;
        logic [7:0] w7;

        rst_n         = 1'b1;
        bus4.in_valid = 1'b0;
        bus4.in_last  = 1'b0;
        bus4.data_in  = '0;
        bus8.in_valid = 1'b0;
        bus8.in_last  = 1'b0;
        bus8.data_in  = '0;
        model_clear();
        #2;
        do_reset("reset");

        tile_basic("basic");

        cycle("stall", 1'b1, 1'b0, col(0));
        cycle("stall", 1'b1, 1'b0, col(1));
        for (int i = 0; i < 3; i++) cycle("stall", 1'b0, 1'b1, 32'hDEADBEEF);
        cycle("stall", 1'b1, 1'b0, col(2));
        cycle("stall", 1'b1, 1'b1, col(3));
        for (int i = 0; i < 5; i++) cycle("stall", 1'b0, 1'b0, '0);

        all_aa = {N4{8'hAA}};
        cycle("single", 1'b1, 1'b1, all_aa);
        chk("single_ch0_aa", 64'(bus4.data_out[7:0]), 64'hAA);
        for (int i = 0; i < 5; i++) begin
            cycle("single", 1'b0, 1'b0, '0);
            if (i < 3) chk("single_ready_low", 64'(bus4.in_ready), 64'h0);
        end
        chk("single_done_gone", 64'(bus4.done), 64'h0);

        cycle("drain_hold", 1'b1, 1'b1, col(5));
        for (int i = 0; i < 5; i++) cycle("drain_hold", 1'b1, 1'b0, 32'h5A5A5A5A);
        cycle("drain_hold", 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle("drain_hold", 1'b0, 1'b0, '0);

        for (int k = 0; k < 4; k++) cycle("midrst", 1'b1, k == 3, col(k));
        cycle("midrst", 1'b0, 1'b0, '0);
        do_reset("midrst_rst");
        for (int i = 0; i < 3; i++) cycle("midrst_after", 1'b0, 1'b0, '0);
        tile_basic("after_rst");

        for (int i = 0; i < 300; i++) begin
            cycle("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), $urandom());
        end
        for (int i = 0; i < 8; i++) cycle("rand_tail", 1'b0, 1'b0, '0);

        // Wider instance: single-beat tile, channel 7 depth 9, drain 9 cycles.
        for (int c = 0; c < N8; c++) bus8.data_in[c*W8 +: W8] = W8'(8'h50 + c);
        bus8.in_valid = 1'b1;
        bus8.in_last  = 1'b1;
        lat0 = 0; lat7 = 0; busy_cnt = 0; done_at = 0; w7 = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            bus8.in_valid = 1'b0;
            bus8.in_last  = 1'b0;
            if (bus8.out_valid[0] && lat0 == 0) lat0 = n;
            if (bus8.out_valid[7] && lat7 == 0) begin
                lat7 = n;
                w7   = bus8.data_out[63:56];
            end
            if (bus8.busy) busy_cnt++;
            if (bus8.done && done_at == 0) done_at = n;
        end
        chk("w8_ch0_latency", 64'(lat0),     64'd2);
        chk("w8_ch7_latency", 64'(lat7),     64'd9);
        chk("w8_ch7_data",    64'(w7),       64'h57);
        chk("w8_busy_cycles", 64'(busy_cnt), 64'd9);
        chk("w8_done_at",     64'(done_at),  64'd10);
        chk("w8_final_valid", 64'(bus8.out_valid), 64'h0);
        chk("w8_final_data",  64'(bus8.data_out),  64'h0);
        chk("w8_final_ready", 64'(bus8.in_ready),  64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
